// File: rtl/ex_mem_stage_pkg.sv
// Shared constants, the per-edge action encoding and its decoder for the EX/MEM register.
// Optional stall counter is enabled by defining EX_MEM_STALL_CNT_EN.
package ex_mem_stage_pkg;

  localparam logic        STOP          = 1'b1;
  localparam logic        NO_STOP       = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
  localparam int          CTX_W_DEFAULT = 66;
  localparam int          CH_GPR        = 0;
  localparam int          CH_HI         = 1;
  localparam int          CH_LO         = 2;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_FLUSH   = 2'd3
  } action_e;

  // Flush outranks any stall; a local stall with a free downstream emits a bubble.
  function automatic action_e decode_action(input logic flush,
                                            input logic s_here,
                                            input logic s_down);
    action_e act;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (s_here == STOP && s_down == NO_STOP) begin
      act = ACT_BUBBLE;
    end else if (s_here == STOP) begin
      act = ACT_HOLD;
    end else begin
      act = ACT_ADVANCE;
    end
    return act;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory bundle: per-channel write ports, valid bit and multi-cycle context.
// The slave modport is the pipeline register; the master modport is the surrounding core.
interface ex_mem_stage_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTX_W  = 66
);
  logic                       in_valid;
  logic [NUM_CH-1:0]          in_we;
  logic [NUM_CH*ADDR_W-1:0]   in_addr;
  logic [NUM_CH*DATA_W-1:0]   in_data;
  logic [CTX_W-1:0]           ctx_i;

  logic                       out_valid;
  logic [NUM_CH-1:0]          out_we;
  logic [NUM_CH*ADDR_W-1:0]   out_addr;
  logic [NUM_CH*DATA_W-1:0]   out_data;
  logic [CTX_W-1:0]           ctx_o;

  modport master (
    output in_valid, in_we, in_addr, in_data, ctx_i,
    input  out_valid, out_we, out_addr, out_data, ctx_o
  );

  modport slave (
    input  in_valid, in_we, in_addr, in_data, ctx_i,
    output out_valid, out_we, out_addr, out_data, ctx_o
  );
endinterface

// File: rtl/ex_mem_stage_stage_slot.sv
// One write channel's we/addr/data register set, steered by the decoded stage action.
module stage_slot
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  action_e           act,
  input  logic              in_valid,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  logic              we_q,   we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // addr/data pass through even when we is low; consumers gate on out_we.
  always_comb begin
    we_d   = we_q;
    addr_d = addr_q;
    data_d = data_q;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        we_d   = 1'b0;
        addr_d = '0;
        data_d = '0;
      end
      ACT_ADVANCE: begin
        we_d   = in_valid & in_we;
        addr_d = in_addr;
        data_d = in_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign out_we   = we_q;
  assign out_addr = addr_q;
  assign out_data = data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid bit, flush, stall-vector indexing and NUM_CH write channels.
// Define EX_MEM_STALL_CNT_EN to add a saturating 16-bit stall-cycle counter.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CTX_W   = CTX_W_DEFAULT,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  ex_mem_stage_if.slave      bus,
  output logic [15:0]        stall_cnt
);

  logic             s_here;
  logic             s_down;
  action_e          act;
  logic             valid_q, valid_d;
  logic [CTX_W-1:0] ctx_q,   ctx_d;
  logic             unused_stall;

  assign s_here = stall[STAGE];

  // The last stage has no downstream neighbour, so it can never be held.
  generate
    if (STAGE + 1 < STALL_W) begin : g_down
      assign s_down = stall[STAGE+1];
    end else begin : g_no_down
      assign s_down = 1'b0;
    end
  endgenerate

  assign unused_stall = ^stall;
  assign act          = decode_action(flush, s_here, s_down);

  always_comb begin
    valid_d = valid_q;
    ctx_d   = ctx_q;
    case (act)
      ACT_FLUSH: begin
        valid_d = 1'b0;
        ctx_d   = '0;
      end
      ACT_BUBBLE: begin
        valid_d = 1'b0;
        ctx_d   = bus.ctx_i;
      end
      ACT_ADVANCE: begin
        valid_d = bus.in_valid;
        ctx_d   = bus.ctx_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctx_q   <= ctx_d;
    end
  end

  logic [NUM_CH-1:0]        we_all;
  logic [NUM_CH*ADDR_W-1:0] addr_all;
  logic [NUM_CH*DATA_W-1:0] data_all;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      stage_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .act      (act),
        .in_valid (bus.in_valid),
        .in_we    (bus.in_we[k]),
        .in_addr  (bus.in_addr[k*ADDR_W +: ADDR_W]),
        .in_data  (bus.in_data[k*DATA_W +: DATA_W]),
        .out_we   (we_all[k]),
        .out_addr (addr_all[k*ADDR_W +: ADDR_W]),
        .out_data (data_all[k*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign bus.out_valid = valid_q;
  assign bus.out_we    = we_all;
  assign bus.out_addr  = addr_all;
  assign bus.out_data  = data_all;
  assign bus.ctx_o     = ctx_q;

`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts BUBBLE and HOLD edges; only reset clears it, flush does not.
  always_comb begin
    cnt_d = cnt_q;
    if (s_here && !flush && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
